// File: rtl/bf_pkg.sv
// Shared definitions for the brainhack program loader: opcodes, states, error codes.
package bf_pkg;

  // 3-bit instruction format: [2:1] selects the unit, [0] selects inc/dec
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_DEC   = 3'b010;
  localparam logic [2:0] OP_INC   = 3'b011;
  localparam logic [2:0] OP_LEFT  = 3'b100;
  localparam logic [2:0] OP_RIGHT = 3'b101;
  localparam logic [2:0] OP_CLOSE = 3'b110;
  localparam logic [2:0] OP_OPEN  = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPad,
    StDone,
    StError
  } loader_state_e;

  localparam logic [2:0] ERR_NONE            = 3'd0;
  localparam logic [2:0] ERR_UNMATCHED_CLOSE = 3'd1;
  localparam logic [2:0] ERR_UNMATCHED_OPEN  = 3'd2;
  localparam logic [2:0] ERR_NEST_OVERFLOW   = 3'd3;
  localparam logic [2:0] ERR_TOO_LONG        = 3'd4;

endpackage

// File: rtl/bf_char_encoder.sv
// Maps an ASCII source byte onto the core instruction encoding.
module bf_char_encoder
  import bf_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_op_o,
  output logic [2:0] opcode_o
);

  // Only the six executable characters are opcodes; everything else is a comment
  always_comb begin
    is_op_o  = 1'b1;
    opcode_o = OP_NOP;
    unique case (char_i)
      8'h2B:   opcode_o = OP_INC;    // '+'
      8'h2D:   opcode_o = OP_DEC;    // '-'
      8'h3E:   opcode_o = OP_RIGHT;  // '>'
      8'h3C:   opcode_o = OP_LEFT;   // '<'
      8'h5B:   opcode_o = OP_OPEN;   // '['
      8'h5D:   opcode_o = OP_CLOSE;  // ']'
      default: is_op_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/bf_program_loader.sv
// Streams Brainfuck source into program memory, pads with NOP, checks bracket
// balance and nesting depth, and releases the core only after a clean load.
module bf_program_loader
  import bf_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH       = 3,
  parameter int unsigned PRGMEM_ADDR_WIDTH = 8,
  parameter int unsigned STACK_ADDR_WIDTH  = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_char_valid,
  input  logic [7:0]                   i_char,
  input  logic                         i_char_last,
  output logic                         o_char_ready,
  output logic                         o_prgmem_we,
  output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
  output logic [INSTR_WIDTH-1:0]       o_prgmem_data,
  output logic [PRGMEM_ADDR_WIDTH:0]   o_prog_len,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_core_run,
  output logic                         o_error,
  output logic [2:0]                   o_error_code
);

  localparam logic [PRGMEM_ADDR_WIDTH:0] MemSize  = {1'b1, {PRGMEM_ADDR_WIDTH{1'b0}}};
  localparam logic [STACK_ADDR_WIDTH:0]  DepthMax = {1'b1, {STACK_ADDR_WIDTH{1'b0}}};

  loader_state_e                state_q, state_d;
  logic [PRGMEM_ADDR_WIDTH:0]   len_q, len_d;
  logic [PRGMEM_ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic [STACK_ADDR_WIDTH:0]    depth_q, depth_d;
  logic [2:0]                   err_q, err_d;
  logic                         we_q, we_d;
  logic [PRGMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [INSTR_WIDTH-1:0]       data_q, data_d;

  logic       is_op;
  logic [2:0] opcode;
  logic       reject;

  bf_char_encoder u_encoder (
    .char_i   (i_char),
    .is_op_o  (is_op),
    .opcode_o (opcode)
  );

  // Next-state: byte checks, write scheduling, padding sweep
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    reject  = 1'b0;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (i_start) begin
          state_d = StLoad;
          len_d   = '0;
          ptr_d   = '0;
          depth_d = '0;
          err_d   = ERR_NONE;
        end
      end
      StLoad: begin
        if (i_char_valid) begin
          if (is_op) begin
            if (len_q == MemSize) begin
              reject = 1'b1;
              err_d  = ERR_TOO_LONG;
            end else if (opcode == OP_CLOSE && depth_q == '0) begin
              reject = 1'b1;
              err_d  = ERR_UNMATCHED_CLOSE;
            end else if (opcode == OP_OPEN && depth_q == DepthMax) begin
              reject = 1'b1;
              err_d  = ERR_NEST_OVERFLOW;
            end else begin
              we_d   = 1'b1;
              addr_d = len_q[PRGMEM_ADDR_WIDTH-1:0];
              data_d = INSTR_WIDTH'(opcode);
              len_d  = len_q + 1'b1;
              if (opcode == OP_OPEN) begin
                depth_d = depth_q + 1'b1;
              end else if (opcode == OP_CLOSE) begin
                depth_d = depth_q - 1'b1;
              end
            end
          end
          if (reject) begin
            state_d = StError;
          end else if (i_char_last) begin
            if (depth_d != '0) begin
              // Memory is undefined on error, so the final write is not issued
              we_d    = 1'b0;
              err_d   = ERR_UNMATCHED_OPEN;
              state_d = StError;
            end else if (len_d == MemSize) begin
              state_d = StDone;
            end else begin
              ptr_d   = len_d;
              state_d = StPad;
            end
          end
        end
      end
      StPad: begin
        we_d   = 1'b1;
        addr_d = ptr_q[PRGMEM_ADDR_WIDTH-1:0];
        data_d = '0;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q[PRGMEM_ADDR_WIDTH-1:0] == '1) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered write port; reset drops any write in flight
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      ptr_q   <= '0;
      depth_q <= '0;
      err_q   <= ERR_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign o_char_ready  = (state_q == StLoad);
  assign o_prgmem_we   = we_q;
  assign o_prgmem_addr = addr_q;
  assign o_prgmem_data = data_q;
  assign o_prog_len    = len_q;
  assign o_busy        = (state_q == StLoad) || (state_q == StPad);
  assign o_done        = (state_q == StDone);
  assign o_core_run    = (state_q == StDone);
  assign o_error       = (state_q == StError);
  assign o_error_code  = err_q;

endmodule
